// File: rtl/vx_axi_write_responder.sv
// AXI4 write slave: turns AW/W bursts into per-beat word-addressed memory writes and queues B responses.
// Optional macro AXI_WRITE_RSP_WLAST_CHECK_EN: flags wlast misplacement as SLVERR.
module vx_axi_write_responder #(
  parameter int AXI_DATA_WIDTH  = 512,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_TID_WIDTH   = 8,
  parameter int RSP_QUEUE_DEPTH = 4,
  parameter int MEM_ADDR_WIDTH  = AXI_ADDR_WIDTH - $clog2(AXI_DATA_WIDTH / 8)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          m_axi_awvalid,
  output logic                          m_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  input  logic [AXI_TID_WIDTH-1:0]      m_axi_awid,
  input  logic [7:0]                    m_axi_awlen,
  input  logic [2:0]                    m_axi_awsize,
  input  logic [1:0]                    m_axi_awburst,
  input  logic [1:0]                    m_axi_awlock,
  input  logic [3:0]                    m_axi_awcache,
  input  logic [2:0]                    m_axi_awprot,
  input  logic [3:0]                    m_axi_awqos,
  input  logic [3:0]                    m_axi_awregion,
  input  logic                          m_axi_wvalid,
  output logic                          m_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  input  logic                          m_axi_wlast,
  output logic                          m_axi_bvalid,
  input  logic                          m_axi_bready,
  output logic [AXI_TID_WIDTH-1:0]      m_axi_bid,
  output logic [1:0]                    m_axi_bresp,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [AXI_DATA_WIDTH-1:0]     mem_req_data,
  output logic [AXI_DATA_WIDTH/8-1:0]   mem_req_byteen
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned PTR_W  = $clog2(RSP_QUEUE_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DRAIN} state_e;

  typedef struct packed {
    logic [AXI_TID_WIDTH-1:0] id;
    logic [1:0]               resp;
  } bq_entry_t;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr_q;
  logic [AXI_TID_WIDTH-1:0]  id_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      err_q;

  bq_entry_t                 bq_mem [RSP_QUEUE_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q;

  logic                      aw_fire_c, aw_err_c, beat_fire_c, last_beat_c, wlast_err_c;
  logic                      bq_push_c, bq_pop_c, bq_full_c, bq_empty_c;
  logic [AXI_ADDR_WIDTH-1:0] size_bytes_c;
  bq_entry_t                 bq_head_c, bq_new_c;
  logic                      unused_sideband;

  assign aw_fire_c    = m_axi_awvalid && m_axi_awready;
  assign aw_err_c     = (m_axi_awburst != BURST_FIXED && m_axi_awburst != BURST_INCR)
                        || (32'(m_axi_awsize) > OFF_W);
  assign beat_fire_c  = m_axi_wvalid && m_axi_wready;
  assign last_beat_c  = (beat_q == len_q);
  assign size_bytes_c = AXI_ADDR_WIDTH'(1) << size_q;

`ifdef AXI_WRITE_RSP_WLAST_CHECK_EN
  assign wlast_err_c     = beat_fire_c && (m_axi_wlast != last_beat_c);
  assign unused_sideband = ^{m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion};
`else
  assign wlast_err_c     = 1'b0;
  assign unused_sideband = ^{m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
                             m_axi_wlast};
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:          if (aw_fire_c) state_d = aw_err_c ? S_DRAIN : S_DATA;
      S_DATA, S_DRAIN: if (beat_fire_c && last_beat_c) state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // FSM outputs; awready is held low while reset is asserted
  always_comb begin
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      S_IDLE:  m_axi_awready = reset && !bq_full_c;
      S_DATA: begin
        m_axi_wready  = mem_req_ready;
        mem_req_valid = m_axi_wvalid;
      end
      S_DRAIN: m_axi_wready = 1'b1;
      default: ;
    endcase
  end

  // Burst context and address walk
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_addr_q <= '0;
      id_q       <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else if (aw_fire_c) begin
      cur_addr_q <= m_axi_awaddr;
      id_q       <= m_axi_awid;
      len_q      <= m_axi_awlen;
      size_q     <= m_axi_awsize;
      burst_q    <= m_axi_awburst;
      beat_q     <= '0;
      err_q      <= aw_err_c;
    end else if (beat_fire_c) begin
      beat_q <= beat_q + 8'd1;
      err_q  <= err_q | wlast_err_c;
      if (state_q == S_DATA && burst_q == BURST_INCR)
        cur_addr_q <= (cur_addr_q & ~(size_bytes_c - AXI_ADDR_WIDTH'(1))) + size_bytes_c;
    end
  end

  assign mem_req_addr   = MEM_ADDR_WIDTH'(cur_addr_q >> OFF_W);
  assign mem_req_data   = m_axi_wdata;
  assign mem_req_byteen = m_axi_wstrb;

  // B response FIFO; push never overflows because full blocks the next AW
  assign bq_push_c     = beat_fire_c && last_beat_c;
  assign bq_pop_c      = m_axi_bvalid && m_axi_bready;
  assign bq_full_c     = (count_q == CNT_W'(RSP_QUEUE_DEPTH));
  assign bq_empty_c    = (count_q == '0);
  assign bq_new_c.id   = id_q;
  assign bq_new_c.resp = (err_q || wlast_err_c) ? RESP_SLVERR : RESP_OKAY;
  assign bq_head_c     = bq_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (bq_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (bq_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({bq_push_c, bq_pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (bq_push_c) bq_mem[wr_ptr_q] <= bq_new_c;
  end

  assign m_axi_bvalid = !bq_empty_c;
  assign m_axi_bid    = bq_empty_c ? '0 : bq_head_c.id;
  assign m_axi_bresp  = bq_empty_c ? '0 : bq_head_c.resp;

endmodule

// File: tb/tb_vx_axi_write_responder.sv
// Directed self-checking bench for vx_axi_write_responder (default parameters).
module tb_vx_axi_write_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         m_axi_awvalid, m_axi_awready;
  logic [31:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awid, m_axi_awlen;
  logic [2:0]   m_axi_awsize, m_axi_awprot;
  logic [1:0]   m_axi_awburst, m_axi_awlock;
  logic [3:0]   m_axi_awcache, m_axi_awqos, m_axi_awregion;
  logic         m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_bvalid, m_axi_bready;
  logic [7:0]   m_axi_bid;
  logic [1:0]   m_axi_bresp;
  logic         mem_req_valid, mem_req_ready;
  logic [25:0]  mem_req_addr;
  logic [511:0] mem_req_data;
  logic [63:0]  mem_req_byteen;

`ifdef AXI_WRITE_RSP_WLAST_CHECK_EN
  localparam logic [1:0] EXP_WL_RESP = 2'b10;
`else
  localparam logic [1:0] EXP_WL_RESP = 2'b00;
`endif

  vx_axi_write_responder dut (
    .clk(clk), .reset(reset),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid),
    .m_axi_bresp(m_axi_bresp),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic aw_fire, w_fire, b_fire, bvalid_s, bv_at_last;
  logic [7:0] b_id;
  logic [1:0] b_resp;
  logic mem_seen, pass_bad, mirror_bad, in_data, rdy_toggle;
  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on negedge; handshakes are observed 1ns later and commit on the next posedge.
  task automatic tick();
    if (rdy_toggle) mem_req_ready = ~mem_req_ready;
    #1;
    aw_fire  = m_axi_awvalid && m_axi_awready;
    w_fire   = m_axi_wvalid && m_axi_wready;
    b_fire   = m_axi_bvalid && m_axi_bready;
    bvalid_s = m_axi_bvalid;
    if (b_fire) begin
      b_id   = m_axi_bid;
      b_resp = m_axi_bresp;
    end
    if (mem_req_valid) begin
      mem_seen = 1'b1;
      if (mem_req_data !== m_axi_wdata || mem_req_byteen !== m_axi_wstrb) pass_bad = 1'b1;
    end
    if (mem_req_valid && mem_req_ready) wr_q.push_back(64'(mem_req_addr));
    if (in_data && m_axi_wvalid && (m_axi_wready !== mem_req_ready)) mirror_bad = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_aw(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (!aw_fire && n < 20);
    m_axi_awvalid = 1'b0;
    if (!aw_fire) check({tag, "_aw_timeout"}, 0, 1);
  endtask

  task automatic do_aw(input string tag, input logic [31:0] addr, input logic [7:0] id,
                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    m_axi_awaddr = addr; m_axi_awid = id; m_axi_awlen = len;
    m_axi_awsize = size; m_axi_awburst = burst; m_axi_awvalid = 1'b1;
    wait_aw(tag);
  endtask

  task automatic send_beats(input string tag, input int n, input int last_idx, output int cyc);
    int k;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      m_axi_wvalid = 1'b1;
      m_axi_wdata  = {16{32'hA500_0000 + 32'(i)}};
      m_axi_wstrb  = {64{1'b1}} ^ 64'(i);
      m_axi_wlast  = (i == last_idx);
      k = 0;
      do begin tick(); k++; cyc++; end while (!w_fire && k < 20);
      if (!w_fire) check({tag, "_w_timeout"}, 0, 1);
      if (i == n - 1) bv_at_last = bvalid_s;
    end
    m_axi_wvalid = 1'b0;
    m_axi_wlast  = 1'b0;
  endtask

  task automatic pop_b(input string tag, input logic [7:0] id, input logic [1:0] resp);
    int n;
    n = 0;
    m_axi_bready = 1'b1;
    b_id = '0; b_resp = '0;
    do begin tick(); n++; end while (!b_fire && n < 20);
    m_axi_bready = 1'b0;
    check({tag, "_bvalid"}, b_fire, 1);
    check({tag, "_bid"}, b_id, id);
    check({tag, "_bresp"}, b_resp, resp);
  endtask

  task automatic check_wr(input string tag);
    check({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wr_q.size()) check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic acc;
    reset = 1'b0;
    m_axi_awvalid = 0; m_axi_awaddr = 0; m_axi_awid = 0; m_axi_awlen = 0; m_axi_awsize = 0;
    m_axi_awburst = 0; m_axi_awlock = 0; m_axi_awcache = 0; m_axi_awprot = 0; m_axi_awqos = 0;
    m_axi_awregion = 0; m_axi_wvalid = 0; m_axi_wdata = 0; m_axi_wstrb = 0; m_axi_wlast = 0;
    m_axi_bready = 0; mem_req_ready = 1;
    mem_seen = 0; pass_bad = 0; mirror_bad = 0; in_data = 0; rdy_toggle = 0; bv_at_last = 0;
    @(negedge clk);
    tick(); tick();
    #1;
    check("rst_awready", m_axi_awready, 0);
    check("rst_wready", m_axi_wready, 0);
    check("rst_memvalid", mem_req_valid, 0);
    check("rst_bvalid", m_axi_bvalid, 0);
    check("rst_bid", m_axi_bid, 0);
    check("rst_bresp", m_axi_bresp, 0);
    reset = 1'b1;
    #1;
    check("post_rst_awready", m_axi_awready, 1);
    m_axi_wvalid = 1'b1;
    #1;
    check("idle_wready", m_axi_wready, 0);
    check("idle_memvalid", mem_req_valid, 0);
    m_axi_wvalid = 1'b0;
    wr_q.delete();
    tick();

    // INCR, 4 x 64B beats from 0x1000
    do_aw("incr", 32'h1000, 8'h05, 8'd3, 3'd6, 2'b01);
    send_beats("incr", 4, 3, cyc);
    check("incr_bv_before", bv_at_last, 0);
    #1;
    check("incr_bv_after", m_axi_bvalid, 1);
    check("incr_awready_after", m_axi_awready, 1);
    exp_q = '{64'h40, 64'h41, 64'h42, 64'h43};
    check_wr("incr");
    pop_b("incr", 8'h05, 2'b00);

    // FIXED with mem_req_ready toggling
    do_aw("fixed", 32'h2000, 8'h07, 8'd2, 3'd6, 2'b00);
    in_data = 1'b1; rdy_toggle = 1'b1; mirror_bad = 1'b0;
    send_beats("fixed", 3, 2, cyc);
    in_data = 1'b0; rdy_toggle = 1'b0; mem_req_ready = 1'b1;
    check("fixed_mirror", mirror_bad, 0);
    exp_q = '{64'h80, 64'h80, 64'h80};
    check_wr("fixed");
    pop_b("fixed", 8'h07, 2'b00);

    // WRAP is drained; memory stalled to show drain ignores it
    mem_req_ready = 1'b0; mem_seen = 1'b0;
    do_aw("wrap", 32'h8000, 8'h09, 8'd1, 3'd6, 2'b10);
    send_beats("wrap", 2, 1, cyc);
    check("wrap_cycles", cyc, 2);
    check("wrap_memseen", mem_seen, 0);
    mem_req_ready = 1'b1;
    check_wr("wrap");
    pop_b("wrap", 8'h09, 2'b10);

    // Oversize awsize
    do_aw("ovsz", 32'h7000, 8'h41, 8'd0, 3'd7, 2'b01);
    send_beats("ovsz", 1, 0, cyc);
    check_wr("ovsz");
    pop_b("ovsz", 8'h41, 2'b10);

    // Unaligned narrow INCR: 0x1030 -> 0x1040 -> 0x1060
    do_aw("unal", 32'h1030, 8'h61, 8'd2, 3'd5, 2'b01);
    send_beats("unal", 3, 2, cyc);
    exp_q = '{64'h40, 64'h41, 64'h41};
    check_wr("unal");
    pop_b("unal", 8'h61, 2'b00);

    // Address wraps modulo 2^32
    do_aw("amod", 32'hFFFF_FFC0, 8'h51, 8'd1, 3'd6, 2'b01);
    send_beats("amod", 2, 1, cyc);
    exp_q = '{64'h3FF_FFFF, 64'h0};
    check_wr("amod");
    pop_b("amod", 8'h51, 2'b00);

    // B FIFO full blocks the fifth AW until one response pops
    for (int j = 0; j < 4; j++) begin
      do_aw("full", 32'h5000 + 32'(j * 64), 8'h11 + 8'(j), 8'd0, 3'd6, 2'b01);
      send_beats("full", 1, 0, cyc);
    end
    m_axi_awaddr = 32'h5100; m_axi_awid = 8'h15; m_axi_awlen = 0; m_axi_awsize = 6;
    m_axi_awburst = 2'b01; m_axi_awvalid = 1'b1;
    acc = 1'b0;
    repeat (3) begin tick(); acc |= aw_fire; end
    check("full_blocked", acc, 0);
    pop_b("full0", 8'h11, 2'b00);
    wait_aw("full5");
    send_beats("full5", 1, 0, cyc);
    pop_b("full1", 8'h12, 2'b00);
    pop_b("full2", 8'h13, 2'b00);
    pop_b("full3", 8'h14, 2'b00);
    pop_b("full4", 8'h15, 2'b00);
    wr_q.delete();

    // wlast on beat 1 of 4
    do_aw("wl", 32'h3000, 8'h31, 8'd3, 3'd6, 2'b01);
    send_beats("wl", 4, 1, cyc);
    exp_q = '{64'hC0, 64'hC1, 64'hC2, 64'hC3};
    check_wr("wl");
    pop_b("wl", 8'h31, EXP_WL_RESP);

    // Reset mid-burst with a queued response
    do_aw("rq", 32'h6000, 8'h21, 8'd0, 3'd6, 2'b01);
    send_beats("rq", 1, 0, cyc);
    do_aw("rm", 32'h6000, 8'h22, 8'd3, 3'd6, 2'b01);
    send_beats("rm", 2, 3, cyc);
    reset = 1'b0;
    tick();
    #1;
    check("rm_rst_awready", m_axi_awready, 0);
    check("rm_rst_bvalid", m_axi_bvalid, 0);
    check("rm_rst_wready", m_axi_wready, 0);
    tick();
    reset = 1'b1;
    #1;
    check("rm_rel_awready", m_axi_awready, 1);
    check("rm_rel_bvalid", m_axi_bvalid, 0);
    wr_q.delete();
    tick();
    do_aw("rn", 32'h4000, 8'h23, 8'd1, 3'd6, 2'b01);
    send_beats("rn", 2, 1, cyc);
    exp_q = '{64'h100, 64'h101};
    check_wr("rn");
    pop_b("rn", 8'h23, 2'b00);
    #1;
    check("rn_bq_empty", m_axi_bvalid, 0);

    check("passthrough", pass_bad, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
